// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the async FIFO: pops entries, packs LANES of them
// into one wide word (first entry in lane 0) and offers it on valid/ready.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                         rd_clk,
  input  logic                         rd_rst,
  output logic                         o_fifo_rd_en,
  input  logic [DSIZE-1:0]             i_fifo_rd_data,
  input  logic                         i_fifo_empty,
  input  logic                         i_flush,
  output logic [DSIZE*LANES-1:0]       o_word,
  output logic [$clog2(LANES+1)-1:0]   o_word_bytes,
  output logic                         o_word_valid,
  input  logic                         i_word_ready,
  output logic                         o_flush_done,
  output logic [CNT_W-1:0]             o_word_count
);

  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW:0]   LANES_W = (CW + 1)'(LANES);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Handshake: a word moves downstream on a rising edge where
  // o_word_valid && i_word_ready; o_word/o_word_bytes hold while valid && !ready.
  logic [0:0]                    state_q, state_d;
  logic [LANES-1:0][DSIZE-1:0]   acc_q, acc_d;
  logic [CW-1:0]                 acc_cnt_q, acc_cnt_d;
  logic                          inflight_q, inflight_d;
  logic [LANES-1:0][DSIZE-1:0]   word_q, word_d;
  logic [CW-1:0]                 word_bytes_q, word_bytes_d;
  logic                          word_valid_q, word_valid_d;
  logic                          flush_done_q, flush_done_d;
  logic [CNT_W-1:0]              word_count_q, word_count_d;

  logic                          slot_free;
  logic                          accept;
  logic                          rd_en;
  logic [LANES-1:0][DSIZE-1:0]   masked;

  // Counting the in-flight read keeps the accumulator from being over-requested.
  assign rd_en = !rd_rst && !i_fifo_empty && (state_q == ST_FILL) && !i_flush &&
                 (({1'b0, acc_cnt_q} + {{CW{1'b0}}, inflight_q}) < LANES_W);

  assign slot_free = !word_valid_q || i_word_ready;
  assign accept    = word_valid_q && i_word_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    inflight_d   = rd_en;
    word_d       = word_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q;
    flush_done_d = 1'b0;
    word_count_d = word_count_q;
    masked       = '0;

    if (accept) begin
      word_valid_d = 1'b0;
      word_count_d = word_count_q + 1'b1;
    end

    // A landing read never coincides with a transfer: reads stop once full.
    if (inflight_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (acc_cnt_q == CW'(k)) acc_d[k] = i_fifo_rd_data;
      end
      acc_cnt_d = acc_cnt_q + 1'b1;
    end

    for (int k = 0; k < LANES; k++) begin
      if (CW'(k) < acc_cnt_q) masked[k] = acc_q[k];
    end

    case (state_q)
      ST_FILL: begin
        if ((acc_cnt_q == LANES_C) && slot_free) begin
          word_d       = acc_q;
          word_bytes_d = LANES_C;
          word_valid_d = 1'b1;
          acc_cnt_d    = '0;
        end
        if (i_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!inflight_q && slot_free) begin
          if (acc_cnt_q != '0) begin
            word_d       = masked;
            word_bytes_d = acc_cnt_q;
            word_valid_d = 1'b1;
            acc_cnt_d    = '0;
          end
          flush_done_d = 1'b1;
          state_d      = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q      <= ST_FILL;
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      word_q       <= '0;
      word_bytes_q <= '0;
      word_valid_q <= 1'b0;
      flush_done_q <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      inflight_q   <= inflight_d;
      word_q       <= word_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
      flush_done_q <= flush_done_d;
      word_count_q <= word_count_d;
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_word       = word_q;
  assign o_word_bytes = word_bytes_q;
  assign o_word_valid = word_valid_q;
  assign o_flush_done = flush_done_q;
  assign o_word_count = word_count_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small registered-read FIFO model.
module tb_fifo_rd_packer;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        empty;
  logic        flush;
  logic [31:0] word;
  logic [2:0]  word_bytes;
  logic        valid;
  logic        ready;
  logic        done;
  logic [15:0] count;

  int checks = 0;
  int failures = 0;
  int rd_en_cnt = 0;
  int valid_cnt = 0;
  int done_cnt = 0;

  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_rd_packer #(.DSIZE(8), .LANES(4), .CNT_W(16)) dut (
    .rd_clk         (clk),
    .rd_rst         (rst),
    .o_fifo_rd_en   (rd_en),
    .i_fifo_rd_data (rd_data),
    .i_fifo_empty   (empty),
    .i_flush        (flush),
    .o_word         (word),
    .o_word_bytes   (word_bytes),
    .o_word_valid   (valid),
    .i_word_ready   (ready),
    .o_flush_done   (done),
    .o_word_count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data, one pop per sampled rd_en.
  assign empty = (wr_ptr == rd_ptr);
  initial rd_data = 8'h00;
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_ptr % 64];
      rd_ptr  <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(negedge clk);
    rd_en_cnt += int'(rd_en);
    valid_cnt += int'(valid);
    done_cnt  += int'(done);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, valid}, 32'd1);
  endtask

  initial begin
    logic stable;
    rst = 1'b1;
    flush = 1'b0;
    ready = 1'b1;

    // Reset held with a non-empty FIFO; these bytes form the first word.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    ticks(4);
    chk("rst_rd_en_cnt", rd_en_cnt, 0);
    chk("rst_valid_cnt", valid_cnt, 0);
    chk("rst_word", word, 32'h0);
    chk("rst_bytes", {29'b0, word_bytes}, 32'd0);
    chk("rst_count", {16'b0, count}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
    rst = 1'b0;

    // Basic pack.
    wait_valid("basic_valid");
    chk("basic_word", word, 32'h44332211);
    chk("basic_bytes", {29'b0, word_bytes}, 32'd4);
    ticks(4);
    chk("basic_valid_cnt", valid_cnt, 1);
    chk("basic_rd_en_cnt", rd_en_cnt, 4);
    chk("basic_count", {16'b0, count}, 32'd1);

    // Backpressure.
    ready = 1'b0;
    rd_en_cnt = 0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    wait_valid("bp_valid");
    chk("bp_word", word, 32'h04030201);
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (word !== 32'h04030201 || word_bytes !== 3'd4 || valid !== 1'b1) stable = 1'b0;
    end
    chk("bp_stable", {31'b0, stable}, 32'd1);
    chk("bp_rd_en_cnt", rd_en_cnt, 8);
    chk("bp_rd_en_idle", {31'b0, rd_en}, 32'd0);
    chk("bp_count_held", {16'b0, count}, 32'd1);
    ready = 1'b1;
    tick();
    chk("bp_word2", word, 32'h08070605);
    chk("bp_valid2", {31'b0, valid}, 32'd1);
    chk("bp_count2", {16'b0, count}, 32'd2);
    tick();
    chk("bp_count3", {16'b0, count}, 32'd3);
    chk("bp_valid_clr", {31'b0, valid}, 32'd0);

    // Partial flush; stale upper lanes must read back as zero.
    rd_en_cnt = 0;
    push(8'hAA); push(8'hBB);
    ticks(5);
    chk("pf_rd_en_cnt", rd_en_cnt, 2);
    valid_cnt = 0;
    done_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_valid("pf_valid");
    chk("pf_word", word, 32'h0000BBAA);
    chk("pf_bytes", {29'b0, word_bytes}, 32'd2);
    chk("pf_done", {31'b0, done}, 32'd1);
    ticks(4);
    chk("pf_done_cnt", done_cnt, 1);
    chk("pf_valid_cnt", valid_cnt, 1);
    chk("pf_count", {16'b0, count}, 32'd4);

    // Flush in the same cycle a third read would have been issued.
    push(8'hAA); push(8'hBB);
    ticks(5);
    push(8'hCC);
    flush = 1'b1;
    #1;
    chk("fi_rd_en_suppressed", {31'b0, rd_en}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fi_rd_en_in_flush", {31'b0, rd_en}, 32'd0);
    wait_valid("fi_valid");
    chk("fi_word", word, 32'h0000BBAA);
    chk("fi_bytes", {29'b0, word_bytes}, 32'd2);
    push(8'hDD); push(8'hEE); push(8'hFF);
    tick();
    wait_valid("fi_next_valid");
    chk("fi_next_word", word, 32'hFFEEDDCC);
    chk("fi_next_bytes", {29'b0, word_bytes}, 32'd4);
    ticks(2);
    chk("fi_count", {16'b0, count}, 32'd6);

    // Flush with an empty accumulator.
    valid_cnt = 0;
    done_cnt = 0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(5);
    chk("ef_valid_cnt", valid_cnt, 0);
    chk("ef_done_cnt", done_cnt, 1);

    // Reset mid-word.
    push(8'h31); push(8'h32); push(8'h33);
    ticks(6);
    rst = 1'b1;
    #1;
    chk("rm_word", word, 32'h0);
    chk("rm_count", {16'b0, count}, 32'd0);
    chk("rm_rd_en", {31'b0, rd_en}, 32'd0);
    tick();
    rst = 1'b0;
    push(8'h5A); push(8'h5B); push(8'h5C); push(8'h5D);
    wait_valid("rm_valid");
    chk("rm_new_word", word, 32'h5D5C5B5A);
    chk("rm_new_bytes", {29'b0, word_bytes}, 32'd4);
    tick();
    chk("rm_new_count", {16'b0, count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
